// File: rtl/axi_ad6676_tx_pkg.sv
// Shared definitions for the AD6676 transmit packer.
//   - tx_state_t : link-side sequencing states (WAIT_LINK / FILL / RUN)
//   - lane_swap  : puts a {s1,s0} lane word into wire order, most significant octet first
//   - pn9_word / pn9_adv16 : PN9 (x^9 + x^5 + 1) test-pattern helpers, 16 bits per sample
// Ports: none (package).
package axi_ad6676_tx_pkg;

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned LANE_W   = 2 * SAMPLE_W;
    localparam int unsigned TX_W     = 2 * LANE_W;

    localparam logic [8:0]  PN9_SEED  = 9'h1ff;
    // Feedback taps for x^9 + x^5 + 1 on a left-shifting register whose MSB is the output bit.
    localparam int unsigned PN9_TAP_A = 8;
    localparam int unsigned PN9_TAP_B = 4;

    typedef enum logic [1:0] {
        WAIT_LINK = 2'd0,
        FILL      = 2'd1,
        RUN       = 2'd2
    } tx_state_t;

    // Lane word {s1,s0} -> {s1[7:0], s1[15:8], s0[7:0], s0[15:8]}
    function automatic logic [LANE_W-1:0] lane_swap(input logic [LANE_W-1:0] w);
        return {w[23:16], w[31:24], w[7:0], w[15:8]};
    endfunction

    // Next 16 PN9 output bits starting from state s; first bit lands in the MSB.
    function automatic logic [SAMPLE_W-1:0] pn9_word(input logic [8:0] s);
        logic [8:0]          r;
        logic [SAMPLE_W-1:0] w;
        r = s;
        w = '0;
        for (int unsigned i = 0; i < SAMPLE_W; i++) begin
            w = {w[SAMPLE_W-2:0], r[PN9_TAP_A]};
            r = {r[7:0], r[PN9_TAP_A] ^ r[PN9_TAP_B]};
        end
        return w;
    endfunction

    // PN9 state after producing one 16-bit word.
    function automatic logic [8:0] pn9_adv16(input logic [8:0] s);
        logic [8:0] r;
        r = s;
        for (int unsigned i = 0; i < SAMPLE_W; i++) begin
            r = {r[7:0], r[PN9_TAP_A] ^ r[PN9_TAP_B]};
        end
        return r;
    endfunction

endpackage

// File: rtl/axi_ad6676_tx_fifo.sv
// Synchronous FIFO decoupling the DAC DMA from the JESD link layer.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   flush          drops all contents (pointers and level to zero)
//   push, wdata    write request / data (accepted when not full, or when a pop frees a slot)
//   pop            read request (ignored when empty); rdata shows the current head
//   level          registered occupancy 0..2**AW
//   full, empty    derived from level
module axi_ad6676_tx_fifo #(
    parameter int unsigned AW = 4,
    parameter int unsigned DW = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // level never exceeds 2**AW, so its MSB alone marks full
    assign full    = level[AW];
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/axi_ad6676_tx_pack.sv
// AD6676 transmit packer: buffers {ch1,ch0} DMA words in a FIFO, waits for the link, prefills
// to START_LEVEL, then streams octet-swapped 64-bit words to the JESD204 TX link layer.
// Underflows in RUN send an all-zero word, pulse dac_dunf and bump a saturating counter.
// Optional feature: define AXI_AD6676_TX_PN_EN to add dac_pn_sel, which replaces every sample
// with PN9 data while in RUN (FIFO still drains as usual).
// Ports:
//   tx_clk, tx_rstn            link clock, asynchronous active-low reset
//   dac_enable_0/1             channel enables; disabled lane carries zeros
//   dac_valid / dac_ready      DMA handshake; dac_data_0/1 = {sample1, sample0}
//   dac_pn_sel                 (AXI_AD6676_TX_PN_EN only) PN9 pattern select
//   tx_ready                   link consumes tx_data this cycle
//   tx_valid, tx_data          registered link word, lane1 = [63:32], lane0 = [31:0]
//   dac_dunf, dac_unf_count    underflow pulse / saturating count
//   fifo_level                 FIFO occupancy
module axi_ad6676_tx_pack
    import axi_ad6676_tx_pkg::*;
#(
    parameter int unsigned FIFO_AW     = 4,
    parameter int unsigned START_LEVEL = 8,
    parameter int unsigned UNF_CNT_W   = 16
) (
    input  logic                 tx_clk,
    input  logic                 tx_rstn,
    input  logic                 dac_enable_0,
    input  logic                 dac_enable_1,
    input  logic                 dac_valid,
    output logic                 dac_ready,
    input  logic [LANE_W-1:0]    dac_data_0,
    input  logic [LANE_W-1:0]    dac_data_1,
`ifdef AXI_AD6676_TX_PN_EN
    input  logic                 dac_pn_sel,
`endif
    input  logic                 tx_ready,
    output logic                 tx_valid,
    output logic [TX_W-1:0]      tx_data,
    output logic                 dac_dunf,
    output logic [UNF_CNT_W-1:0] dac_unf_count,
    output logic [FIFO_AW:0]     fifo_level
);

    localparam logic [FIFO_AW+1:0] START_L = (FIFO_AW+2)'(START_LEVEL);

    tx_state_t          state;
    logic               accept_en;
    logic               any_en;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic               link_go;
    logic               underflow;
    logic               fill_done;
    logic               enter_run;
    logic [FIFO_AW+1:0] level_after_push;
    logic [TX_W-1:0]    head;
    logic [LANE_W-1:0]  lane0_src;
    logic [LANE_W-1:0]  lane1_src;
    logic [LANE_W-1:0]  lane0;
    logic [LANE_W-1:0]  lane1;
    logic [TX_W-1:0]    pack_data;

    assign any_en    = dac_enable_0 || dac_enable_1;
    // accept_en keeps dac_ready low while in reset
    assign dac_ready = accept_en && !full && any_en;
    assign push      = dac_valid && dac_ready;

    assign link_go   = (state == RUN) && tx_ready && any_en;
    assign pop       = link_go && !empty;
    assign underflow = link_go && empty;

    // No pop happens in FILL, so the post-push occupancy is level + push.
    assign level_after_push = {1'b0, fifo_level} + {{(FIFO_AW+1){1'b0}}, push};
    assign fill_done        = (state == FILL) && (level_after_push >= START_L);
    assign enter_run        = fill_done && any_en;

    axi_ad6676_tx_fifo #(
        .AW (FIFO_AW),
        .DW (TX_W)
    ) u_fifo (
        .clk   (tx_clk),
        .rst_n (tx_rstn),
        .flush (!any_en),
        .push  (push),
        .pop   (pop),
        .wdata ({dac_data_1, dac_data_0}),
        .rdata (head),
        .level (fifo_level),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge tx_clk or negedge tx_rstn) begin
        if (!tx_rstn) begin
            accept_en <= 1'b0;
        end else begin
            accept_en <= 1'b1;
        end
    end

`ifdef AXI_AD6676_TX_PN_EN
    // Four consecutive 16-bit PN words per link word: ch0 s0, ch0 s1, ch1 s0, ch1 s1.
    // PN state advances only on popped words, so underflow cycles do not consume pattern.
    logic [8:0]          pn_state;
    logic [8:0]          pn_s1;
    logic [8:0]          pn_s2;
    logic [8:0]          pn_s3;
    logic [8:0]          pn_s4;
    logic [SAMPLE_W-1:0] pn_w0;
    logic [SAMPLE_W-1:0] pn_w1;
    logic [SAMPLE_W-1:0] pn_w2;
    logic [SAMPLE_W-1:0] pn_w3;

    always_comb begin
        pn_s1 = pn9_adv16(pn_state);
        pn_s2 = pn9_adv16(pn_s1);
        pn_s3 = pn9_adv16(pn_s2);
        pn_s4 = pn9_adv16(pn_s3);
        pn_w0 = pn9_word(pn_state);
        pn_w1 = pn9_word(pn_s1);
        pn_w2 = pn9_word(pn_s2);
        pn_w3 = pn9_word(pn_s3);
    end

    always_ff @(posedge tx_clk or negedge tx_rstn) begin
        if (!tx_rstn) begin
            pn_state <= PN9_SEED;
        end else if (enter_run) begin
            pn_state <= PN9_SEED;
        end else if (pop && dac_pn_sel) begin
            pn_state <= pn_s4;
        end
    end

    always_comb begin
        lane0_src = head[LANE_W-1:0];
        lane1_src = head[TX_W-1:LANE_W];
        if (dac_pn_sel) begin
            lane0_src = {pn_w1, pn_w0};
            lane1_src = {pn_w3, pn_w2};
        end
    end
`else
    always_comb begin
        lane0_src = head[LANE_W-1:0];
        lane1_src = head[TX_W-1:LANE_W];
    end
`endif

    always_comb begin
        lane0 = '0;
        lane1 = '0;
        if (dac_enable_0) begin
            lane0 = lane_swap(lane0_src);
        end
        if (dac_enable_1) begin
            lane1 = lane_swap(lane1_src);
        end
        pack_data = {lane1, lane0};
    end

    // Sequencer; tx_valid is registered alongside the state so it equals (state == RUN).
    always_ff @(posedge tx_clk or negedge tx_rstn) begin
        if (!tx_rstn) begin
            state    <= WAIT_LINK;
            tx_valid <= 1'b0;
        end else if (!any_en) begin
            state    <= WAIT_LINK;
            tx_valid <= 1'b0;
        end else begin
            unique case (state)
                WAIT_LINK: begin
                    if (tx_ready) begin
                        state <= FILL;
                    end
                end
                FILL: begin
                    if (fill_done) begin
                        state    <= RUN;
                        tx_valid <= 1'b1;
                    end
                end
                RUN: begin
                    if (!tx_ready) begin
                        state    <= WAIT_LINK;
                        tx_valid <= 1'b0;
                    end
                end
                default: begin
                    state    <= WAIT_LINK;
                    tx_valid <= 1'b0;
                end
            endcase
        end
    end

    // Link word, underflow pulse and saturating underflow counter.
    always_ff @(posedge tx_clk or negedge tx_rstn) begin
        if (!tx_rstn) begin
            tx_data       <= '0;
            dac_dunf      <= 1'b0;
            dac_unf_count <= '0;
        end else begin
            dac_dunf <= underflow;
            if (underflow) begin
                tx_data <= '0;
                if (dac_unf_count != '1) begin
                    dac_unf_count <= dac_unf_count + UNF_CNT_W'(1);
                end
            end else if (pop) begin
                tx_data <= pack_data;
            end
        end
    end

endmodule

// File: tb/tb_axi_ad6676_tx_pack.sv
`timescale 1ns/1ps
module tb_axi_ad6676_tx_pack;

    localparam int AW      = 4;
    localparam int DEPTH   = 16;
    localparam int START   = 8;
    localparam int UW      = 3;
    localparam int CNT_MAX = (1 << UW) - 1;

    logic          tx_clk = 1'b0;
    logic          tx_rstn;
    logic          dac_enable_0;
    logic          dac_enable_1;
    logic          dac_valid;
    logic          dac_ready;
    logic [31:0]   dac_data_0;
    logic [31:0]   dac_data_1;
    logic          dac_pn_sel;
    logic          tx_ready;
    logic          tx_valid;
    logic [63:0]   tx_data;
    logic          dac_dunf;
    logic [UW-1:0] dac_unf_count;
    logic [AW:0]   fifo_level;

    always #5 tx_clk = ~tx_clk;

    axi_ad6676_tx_pack #(
        .FIFO_AW     (AW),
        .START_LEVEL (START),
        .UNF_CNT_W   (UW)
    ) dut (
        .tx_clk        (tx_clk),
        .tx_rstn       (tx_rstn),
        .dac_enable_0  (dac_enable_0),
        .dac_enable_1  (dac_enable_1),
        .dac_valid     (dac_valid),
        .dac_ready     (dac_ready),
        .dac_data_0    (dac_data_0),
        .dac_data_1    (dac_data_1),
`ifdef AXI_AD6676_TX_PN_EN
        .dac_pn_sel    (dac_pn_sel),
`endif
        .tx_ready      (tx_ready),
        .tx_valid      (tx_valid),
        .tx_data       (tx_data),
        .dac_dunf      (dac_dunf),
        .dac_unf_count (dac_unf_count),
        .fifo_level    (fifo_level)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum {M_WAIT, M_FILL, M_RUN} mstate_t;
    mstate_t     m_state;
    logic [63:0] q[$];
    logic [63:0] m_data;
    logic        m_dunf;
    int          m_cnt;
    logic        m_valid;
    bit          m_live;
    bit          pn_bits[511];
    int          pn_pos;

    function automatic logic [31:0] swap_lane(input logic [31:0] w);
        return ((w & 32'h00ff00ff) << 8) | ((w >> 8) & 32'h00ff00ff);
    endfunction

    function automatic logic [15:0] pn_take16();
        logic [15:0] w;
        w = '0;
        for (int i = 0; i < 16; i++) begin
            w = (w << 1) | 16'(pn_bits[pn_pos]);
            pn_pos = (pn_pos + 1) % 511;
        end
        return w;
    endfunction

    function automatic logic [63:0] pack_word(input logic [63:0] w);
        logic [31:0] l0, l1;
        logic [15:0] p0, p1, p2, p3;
        l0 = w[31:0];
        l1 = w[63:32];
        if (dac_pn_sel) begin
            p0 = pn_take16();
            p1 = pn_take16();
            p2 = pn_take16();
            p3 = pn_take16();
            l0 = {p1, p0};
            l1 = {p3, p2};
        end
        l0 = dac_enable_0 ? swap_lane(l0) : 32'h0;
        l1 = dac_enable_1 ? swap_lane(l1) : 32'h0;
        return {l1, l0};
    endfunction

    function automatic bit model_ready();
        return m_live && (q.size() < DEPTH) && (dac_enable_0 || dac_enable_1);
    endfunction

    task automatic model_reset();
        m_state = M_WAIT;
        q.delete();
        m_data  = '0;
        m_dunf  = 1'b0;
        m_cnt   = 0;
        m_valid = 1'b0;
        m_live  = 1'b0;
        pn_pos  = 0;
    endtask

    task automatic model_step();
        bit any, rdy, go;
        any = dac_enable_0 || dac_enable_1;
        rdy = model_ready();
        go  = (m_state == M_RUN) && tx_ready && any;
        m_dunf = 1'b0;
        if (go && q.size() == 0) begin
            m_data = '0;
            m_dunf = 1'b1;
            if (m_cnt < CNT_MAX) m_cnt++;
        end else if (go) begin
            m_data = pack_word(q.pop_front());
        end
        if (dac_valid && rdy) q.push_back({dac_data_1, dac_data_0});
        if (!any) begin
            m_state = M_WAIT;
            q.delete();
        end else begin
            case (m_state)
                M_WAIT: if (tx_ready) m_state = M_FILL;
                M_FILL: if (q.size() >= START) begin
                    m_state = M_RUN;
                    pn_pos  = 0;
                end
                default: if (!tx_ready) m_state = M_WAIT;
            endcase
        end
        m_valid = (m_state == M_RUN);
        m_live  = 1'b1;
    endtask

    task automatic compare_outputs(input string p);
        check({p, "_valid"}, tx_valid, m_valid);
        check({p, "_data"}, tx_data, m_data);
        check({p, "_dunf"}, dac_dunf, m_dunf);
        check({p, "_cnt"}, dac_unf_count, m_cnt);
        check({p, "_level"}, fifo_level, q.size());
    endtask

    // Inputs are already driven; check ready, advance the model, clock, then compare.
    task automatic cycle(input string tag);
        #1;
        check({tag, "_ready"}, dac_ready, model_ready());
        model_step();
        @(posedge tx_clk);
        #1;
        compare_outputs(tag);
    endtask

    task automatic set_in(input bit e0, input bit e1, input bit v, input bit tr);
        dac_enable_0 = e0;
        dac_enable_1 = e1;
        dac_valid    = v;
        tx_ready     = tr;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          dunf_seen;
        logic [63:0] held;
        logic [15:0] pn_first;
        logic [8:0]  s;
        int unsigned r;

        s = 9'h1ff;
        for (int i = 0; i < 511; i++) begin
            pn_bits[i] = s[8];
            s = {s[7:0], s[8] ^ s[4]};
        end
        pn_first = '0;
        for (int i = 0; i < 16; i++) pn_first = (pn_first << 1) | 16'(pn_bits[i]);

        tx_rstn    = 1'b0;
        dac_pn_sel = 1'b0;
        dac_data_0 = '0;
        dac_data_1 = '0;
        set_in(0, 0, 0, 0);
        model_reset();
        repeat (3) @(posedge tx_clk);
        #1;
        compare_outputs("rst");
        check("rst_ready", dac_ready, 1'b0);
        tx_rstn = 1'b1;
        cycle("idle");

        // Prefill with 8 identical words, then first link word.
        set_in(1, 1, 1, 1);
        dac_data_0 = 32'h1234_5678;
        dac_data_1 = 32'h9abc_def0;
        for (int i = 0; i < 8; i++) cycle("t2_fill");
        check("t2_run_valid", tx_valid, 1'b1);
        dac_valid = 1'b0;
        cycle("t2_pop");
        check("t2_first_word", tx_data, 64'hbc9a_f0de_3412_7856);
        for (int i = 0; i < 7; i++) cycle("t2_drain");

        // Three underflows.
        dunf_seen = 0;
        for (int i = 0; i < 3; i++) begin
            cycle("t3_unf");
            if (dac_dunf === 1'b1) dunf_seen++;
        end
        check("t3_dunf_pulses", dunf_seen, 3);
        check("t3_unf_count", dac_unf_count, 3);
        check("t3_data_zero", tx_data, 64'h0);

        // Counter saturation.
        for (int i = 0; i < 10; i++) cycle("t4_unf");
        check("t4_saturated", dac_unf_count, CNT_MAX);
        check("t4_still_run", tx_valid, 1'b1);

        // Fill to full with link stalled.
        set_in(1, 1, 1, 0);
        for (int i = 0; i < 20; i++) begin
            dac_data_0 = $urandom;
            dac_data_1 = $urandom;
            cycle("t5_fill");
        end
        check("t5_full_level", fifo_level, DEPTH);
        check("t5_full_ready", dac_ready, 1'b0);
        tx_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            dac_data_0 = $urandom;
            dac_data_1 = $urandom;
            cycle("t5_pushpop");
        end
        check("t5_level_steady", fifo_level, DEPTH - 1);
        held = m_data;
        set_in(1, 1, 0, 0);
        for (int i = 0; i < 4; i++) cycle("t5_stall");
        check("t5_hold_data", tx_data, held);
        check("t5_wait_valid", tx_valid, 1'b0);
        check("t5_no_pop", fifo_level, DEPTH - 1);

        // Channel 1 disabled (plus PN on channel 0 when built in).
        set_in(1, 0, 0, 1);
`ifdef AXI_AD6676_TX_PN_EN
        dac_pn_sel = 1'b1;
`endif
        for (int i = 0; i < 3; i++) cycle("t6_start");
        check("t6_lane1_zero", tx_data[63:32], 32'h0);
`ifdef AXI_AD6676_TX_PN_EN
        check("t6_pn_first", tx_data[15:0], {pn_first[7:0], pn_first[15:8]});
`endif
        dac_pn_sel = 1'b0;
        cycle("t6_pop2");
        check("t6_drain", fifo_level, DEPTH - 3);
        check("t6_lane1_zero2", tx_data[63:32], 32'h0);

        // Asynchronous reset in RUN at level 5.
        set_in(1, 1, 0, 1);
        for (int i = 0; i < 20; i++) begin
            if (q.size() == 5) break;
            cycle("t1_drain");
        end
        check("t1_level5", fifo_level, 5);
        tx_rstn = 1'b0;
        model_reset();
        #1;
        compare_outputs("t1_rst");
        check("t1_rst_ready", dac_ready, 1'b0);
        @(posedge tx_clk);
        #1;
        compare_outputs("t1_rst_hold");
        tx_rstn = 1'b1;
        cycle("t1_after");

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 3)       set_in(0, 0, 0, 0);
            else if (r < 10) set_in(1, 0, 0, 0);
            else if (r < 15) set_in(0, 1, 0, 0);
            else             set_in(1, 1, 0, 0);
            dac_valid  = ($urandom_range(0, 99) < 60);
            tx_ready   = ($urandom_range(0, 99) < 85);
            dac_data_0 = $urandom;
            dac_data_1 = $urandom;
`ifdef AXI_AD6676_TX_PN_EN
            dac_pn_sel = ($urandom_range(0, 3) == 0);
`endif
            cycle("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
